// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: widths, RV32I opcodes, immediate formats,
// and the immediate/control decode helpers used by id_stage.
package id_stage_pkg;

  localparam int XLEN  = 32;
  localparam int PC_W  = 15;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     use_rs1;
    logic     use_rs2;
    imm_fmt_e fmt;
  } ctrl_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Unknown opcodes fall through with every control low, so they travel as a NOP.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    c.fmt = IMM_NONE;
    case (opc)
      OPC_OP:     begin c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
      OPC_OP_IMM: begin c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
      OPC_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
      OPC_STORE:  begin c.mem_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_S; end
      OPC_BRANCH: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_B; end
      OPC_LUI:    begin c.reg_write = 1'b1; c.fmt = IMM_U; end
      OPC_AUIPC:  begin c.reg_write = 1'b1; c.fmt = IMM_U; end
      OPC_JAL:    begin c.reg_write = 1'b1; c.fmt = IMM_J; end
      OPC_JALR:   begin c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.fmt = IMM_I; end
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 fixed at 0.
// Macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module id_stage_reg_file
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wr_addr != 5'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (i_wr_addr == i_rs1_addr)) o_rs1_data = i_wr_data;
    if (w_wr_en && (i_wr_addr == i_rs2_addr)) o_rs2_data = i_wr_data;
`else
    // Without bypass the old value is returned; EXE forwards from WB instead.
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file read, immediate/control decode, load-use stall, ID/EX register.
// Optional macro REGFILE_BYPASS_EN (in id_stage_reg_file) enables same-cycle write-to-read bypass.
module id_stage
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_IF_ID,
  input  logic [PC_W-1:0] pc_IF_ID,
  input  logic            flush_EXE,
  input  logic            reg_write_WB,
  input  logic [4:0]      rd_WB,
  input  logic [XLEN-1:0] write_data_WB,
  output logic            pc_write_HZRD,
  output logic            valid_ID_EXE,
  output logic [PC_W-1:0] pc_ID_EXE,
  output logic [XLEN-1:0] rs1_data_ID_EXE,
  output logic [XLEN-1:0] rs2_data_ID_EXE,
  output logic [XLEN-1:0] imm_ID_EXE,
  output logic [4:0]      rs1_ID_EXE,
  output logic [4:0]      rs2_ID_EXE,
  output logic [4:0]      rd_ID_EXE,
  output logic [6:0]      opcode_ID_EXE,
  output logic [2:0]      funct3_ID_EXE,
  output logic            funct7b5_ID_EXE,
  output logic            reg_write_ID_EXE,
  output logic            mem_read_ID_EXE,
  output logic            mem_write_ID_EXE
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_bubble;

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;

  assign w_opcode   = instruction_IF_ID[6:0];
  assign w_rd       = instruction_IF_ID[11:7];
  assign w_funct3   = instruction_IF_ID[14:12];
  assign w_rs1      = instruction_IF_ID[19:15];
  assign w_rs2      = instruction_IF_ID[24:20];
  assign w_funct7b5 = instruction_IF_ID[30];
  assign w_ctrl     = decode_ctrl(w_opcode);
  assign w_imm      = gen_imm(instruction_IF_ID, w_ctrl.fmt);

  id_stage_reg_file u_reg_file (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (reg_write_WB),
    .i_wr_addr  (rd_WB),
    .i_wr_data  (write_data_WB)
  );

  // Handshake with IF: pc_write_HZRD acts as ready. instruction_IF_ID/pc_IF_ID are consumed on a
  // posedge only while it is 1; at 0 IF holds and re-presents the same instruction next cycle.
  // A flush always wins so the EXE redirect is accepted even when a stall is pending.
  assign w_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                    ((w_ctrl.use_rs1 && (r_rd == w_rs1)) ||
                     (w_ctrl.use_rs2 && (r_rd == w_rs2)));
  assign w_bubble      = w_hazard || flush_EXE;
  assign pc_write_HZRD = !w_hazard || flush_EXE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7b5  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_valid     <= !w_bubble;
      r_pc        <= pc_IF_ID;
      r_rs1_data  <= w_rs1_data;
      r_rs2_data  <= w_rs2_data;
      r_imm       <= w_imm;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_opcode    <= w_opcode;
      r_funct3    <= w_funct3;
      r_funct7b5  <= w_funct7b5;
      r_reg_write <= w_ctrl.reg_write && !w_bubble;
      r_mem_read  <= w_ctrl.mem_read && !w_bubble;
      r_mem_write <= w_ctrl.mem_write && !w_bubble;
    end
  end

  assign valid_ID_EXE     = r_valid;
  assign pc_ID_EXE        = r_pc;
  assign rs1_data_ID_EXE  = r_rs1_data;
  assign rs2_data_ID_EXE  = r_rs2_data;
  assign imm_ID_EXE       = r_imm;
  assign rs1_ID_EXE       = r_rs1;
  assign rs2_ID_EXE       = r_rs2;
  assign rd_ID_EXE        = r_rd;
  assign opcode_ID_EXE    = r_opcode;
  assign funct3_ID_EXE    = r_funct3;
  assign funct7b5_ID_EXE  = r_funct7b5;
  assign reg_write_ID_EXE = r_reg_write;
  assign mem_read_ID_EXE  = r_mem_read;
  assign mem_write_ID_EXE = r_mem_write;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued when an instruction is driven
// and compared after the following posedge; pc_write_HZRD is checked combinationally.
module tb_id_stage;

  localparam int VW = 141;
  localparam logic [VW-1:0] M_ALL  = {VW{1'b1}};
  localparam logic [VW-1:0] M_CTRL = {4'hF, {(VW-4){1'b0}}};
  localparam logic [VW-1:0] BUB    = '0;
`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_X9 = 32'h0000_0055;
`else
  localparam logic [31:0] BYP_X9 = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_IF_ID;
  logic [14:0] pc_IF_ID;
  logic        flush_EXE;
  logic        reg_write_WB;
  logic [4:0]  rd_WB;
  logic [31:0] write_data_WB;
  logic        pc_write_HZRD;
  logic        valid_ID_EXE;
  logic [14:0] pc_ID_EXE;
  logic [31:0] rs1_data_ID_EXE;
  logic [31:0] rs2_data_ID_EXE;
  logic [31:0] imm_ID_EXE;
  logic [4:0]  rs1_ID_EXE;
  logic [4:0]  rs2_ID_EXE;
  logic [4:0]  rd_ID_EXE;
  logic [6:0]  opcode_ID_EXE;
  logic [2:0]  funct3_ID_EXE;
  logic        funct7b5_ID_EXE;
  logic        reg_write_ID_EXE;
  logic        mem_read_ID_EXE;
  logic        mem_write_ID_EXE;
  logic [VW-1:0] obs;

  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] msk_q[$];

  id_stage dut (
    .clk               (clk),
    .reset             (reset),
    .instruction_IF_ID (instruction_IF_ID),
    .pc_IF_ID          (pc_IF_ID),
    .flush_EXE         (flush_EXE),
    .reg_write_WB      (reg_write_WB),
    .rd_WB             (rd_WB),
    .write_data_WB     (write_data_WB),
    .pc_write_HZRD     (pc_write_HZRD),
    .valid_ID_EXE      (valid_ID_EXE),
    .pc_ID_EXE         (pc_ID_EXE),
    .rs1_data_ID_EXE   (rs1_data_ID_EXE),
    .rs2_data_ID_EXE   (rs2_data_ID_EXE),
    .imm_ID_EXE        (imm_ID_EXE),
    .rs1_ID_EXE        (rs1_ID_EXE),
    .rs2_ID_EXE        (rs2_ID_EXE),
    .rd_ID_EXE         (rd_ID_EXE),
    .opcode_ID_EXE     (opcode_ID_EXE),
    .funct3_ID_EXE     (funct3_ID_EXE),
    .funct7b5_ID_EXE   (funct7b5_ID_EXE),
    .reg_write_ID_EXE  (reg_write_ID_EXE),
    .mem_read_ID_EXE   (mem_read_ID_EXE),
    .mem_write_ID_EXE  (mem_write_ID_EXE)
  );

  assign obs = {valid_ID_EXE, reg_write_ID_EXE, mem_read_ID_EXE, mem_write_ID_EXE,
                rd_ID_EXE, rs1_ID_EXE, rs2_ID_EXE, opcode_ID_EXE, funct3_ID_EXE,
                funct7b5_ID_EXE, imm_ID_EXE, rs1_data_ID_EXE, rs2_data_ID_EXE, pc_ID_EXE};

  // clock
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pk(
    input logic v, input logic rw, input logic mr, input logic mw,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [6:0] op, input logic [2:0] f3, input logic f7,
    input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2, input logic [14:0] pc);
    return {v, rw, mr, mw, rd, rs1, rs2, op, f3, f7, imm, d1, d2, pc};
  endfunction

  // One clock: drive at negedge, check pc_write_HZRD, check ID/EX after the posedge.
  task automatic cycle(
    input string tag, input logic rst, input logic [31:0] ins, input logic [14:0] pc,
    input logic fl, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
    input logic chk_pw, input logic exp_pw, input logic [VW-1:0] ev, input logic [VW-1:0] em);
    logic [VW-1:0] e;
    logic [VW-1:0] m;
    reset             = rst;
    instruction_IF_ID = ins;
    pc_IF_ID          = pc;
    flush_EXE         = fl;
    reg_write_WB      = we;
    rd_WB             = wrd;
    write_data_WB     = wd;
    exp_q.push_back(ev & em);
    msk_q.push_back(em);
    #1;
    if (chk_pw) begin
      vectors++;
      assert (pc_write_HZRD === exp_pw)
      else begin
        miscompares++;
        $error("FAIL %s pc_write_HZRD observed=%b expected=%b", tag, pc_write_HZRD, exp_pw);
      end
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    vectors++;
    assert ((obs & m) === e)
    else begin
      miscompares++;
      $error("FAIL %s id_ex observed=%h expected=%h", tag, obs & m, e);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; instruction_IF_ID = '0; pc_IF_ID = '0; flush_EXE = 1'b0;
    reg_write_WB = 1'b0; rd_WB = '0; write_data_WB = '0;
    @(negedge clk);
    cycle("reset1", 1, 32'h0, 15'h0, 0, 0, 0, 0, 0, 1, BUB, M_ALL);
    cycle("reset2", 1, 32'h0, 15'h0, 0, 0, 0, 0, 1, 1, BUB, M_ALL);
    cycle("nop_wb_x5", 0, 32'h0000_0000, 15'h10, 0, 1, 5'd5, 32'hDEAD_BEEF, 1, 1,
          pk(1,0,0,0, 0,0,0, 7'h00,0,0, 0, 0, 0, 15'h10), M_ALL);
    cycle("addi_x6_x5", 0, 32'h0012_8313, 15'h14, 0, 1, 5'd2, 32'h22, 1, 1,
          pk(1,1,0,0, 6,5,1, 7'h13,0,0, 32'h1, 32'hDEAD_BEEF, 0, 15'h14), M_ALL);
    cycle("lw_x7", 0, 32'h0000_A383, 15'h18, 0, 1, 5'd7, 32'h777, 1, 1,
          pk(1,1,1,0, 7,1,0, 7'h03,2,0, 0, 0, 0, 15'h18), M_ALL);
    cycle("add_stall", 0, 32'h0023_8433, 15'h1C, 0, 0, 0, 0, 1, 0, BUB, M_CTRL);
    cycle("add_issue", 0, 32'h0023_8433, 15'h1C, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 8,7,2, 7'h33,0,0, 0, 32'h777, 32'h22, 15'h1C), M_ALL);
    cycle("lw_x7_b", 0, 32'h0000_A383, 15'h20, 0, 0, 0, 0, 1, 1,
          pk(1,1,1,0, 7,1,0, 7'h03,2,0, 0, 0, 0, 15'h20), M_ALL);
    cycle("flush_over_stall", 0, 32'h0023_8433, 15'h24, 1, 0, 0, 0, 1, 1, BUB, M_CTRL);
    cycle("lw_x7_c", 0, 32'h0000_A383, 15'h28, 0, 0, 0, 0, 1, 1,
          pk(1,1,1,0, 7,1,0, 7'h03,2,0, 0, 0, 0, 15'h28), M_ALL);
    cycle("sw_rs2_stall", 0, 32'h0070_A023, 15'h2C, 0, 0, 0, 0, 1, 0, BUB, M_CTRL);
    cycle("sw_issue", 0, 32'h0070_A023, 15'h2C, 0, 0, 0, 0, 1, 1,
          pk(1,0,0,1, 0,1,7, 7'h23,2,0, 0, 0, 32'h777, 15'h2C), M_ALL);
    cycle("lw_x7_d", 0, 32'h0000_A383, 15'h30, 0, 0, 0, 0, 1, 1,
          pk(1,1,1,0, 7,1,0, 7'h03,2,0, 0, 0, 0, 15'h30), M_ALL);
    cycle("addi_rs2field_nostall", 0, 32'h0070_0093, 15'h34, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 1,0,7, 7'h13,0,0, 32'h7, 0, 32'h777, 15'h34), M_ALL);
    cycle("lw_x0", 0, 32'h0000_2003, 15'h38, 0, 0, 0, 0, 1, 1,
          pk(1,1,1,0, 0,0,0, 7'h03,2,0, 0, 0, 0, 15'h38), M_ALL);
    cycle("add_after_lw_x0", 0, 32'h0000_0433, 15'h3C, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 8,0,0, 7'h33,0,0, 0, 0, 0, 15'h3C), M_ALL);
    cycle("lw_x5", 0, 32'h0000_2283, 15'h40, 0, 0, 0, 0, 1, 1,
          pk(1,1,1,0, 5,0,0, 7'h03,2,0, 0, 0, 0, 15'h40), M_ALL);
    cycle("lui_nostall", 0, 32'h8002_8537, 15'h44, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 10,5,0, 7'h37,0,0, 32'h8002_8000, 32'hDEAD_BEEF, 0, 15'h44), M_ALL);
    cycle("sw_neg8", 0, 32'hFE53_2C23, 15'h48, 0, 0, 0, 0, 1, 1,
          pk(1,0,0,1, 24,6,5, 7'h23,2,1, 32'hFFFF_FFF8, 0, 32'hDEAD_BEEF, 15'h48), M_ALL);
    cycle("beq_min", 0, 32'h8000_0063, 15'h4C, 0, 0, 0, 0, 1, 1,
          pk(1,0,0,0, 0,0,0, 7'h63,0,0, 32'hFFFF_F000, 0, 0, 15'h4C), M_ALL);
    cycle("beq_bit11", 0, 32'h0000_00E3, 15'h50, 0, 0, 0, 0, 1, 1,
          pk(1,0,0,0, 1,0,0, 7'h63,0,0, 32'h0000_0800, 0, 0, 15'h50), M_ALL);
    cycle("jal_mid", 0, 32'h001F_F0EF, 15'h54, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 1,31,1, 7'h6F,7,0, 32'h000F_F800, 0, 0, 15'h54), M_ALL);
    cycle("jal_neg2", 0, 32'hFFFF_F0EF, 15'h58, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 1,31,31, 7'h6F,7,1, 32'hFFFF_FFFE, 0, 0, 15'h58), M_ALL);
    cycle("jalr_neg4", 0, 32'hFFC2_80E7, 15'h5C, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 1,5,28, 7'h67,0,1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 15'h5C), M_ALL);
    cycle("auipc", 0, 32'hFFFF_F517, 15'h60, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 10,31,31, 7'h17,7,1, 32'hFFFF_F000, 0, 0, 15'h60), M_ALL);
    cycle("wb_x0_same", 0, 32'h0000_0593, 15'h64, 0, 1, 5'd0, 32'h1234, 1, 1,
          pk(1,1,0,0, 11,0,0, 7'h13,0,0, 0, 0, 0, 15'h64), M_ALL);
    cycle("x0_after_wb", 0, 32'h0000_0593, 15'h68, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 11,0,0, 7'h13,0,0, 0, 0, 0, 15'h68), M_ALL);
    cycle("x9_same_cycle", 0, 32'h0004_8613, 15'h6C, 0, 1, 5'd9, 32'h55, 1, 1,
          pk(1,1,0,0, 12,9,0, 7'h13,0,0, 0, BYP_X9, 0, 15'h6C), M_ALL);
    cycle("x9_next_cycle", 0, 32'h0004_8613, 15'h70, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 12,9,0, 7'h13,0,0, 0, 32'h55, 0, 15'h70), M_ALL);
    cycle("reset_mid", 1, 32'h0000_A383, 15'h74, 0, 0, 0, 0, 1, 1, BUB, M_ALL);
    cycle("addi_after_reset", 0, 32'h0012_8313, 15'h78, 0, 0, 0, 0, 1, 1,
          pk(1,1,0,0, 6,5,1, 7'h13,0,0, 32'h1, 0, 0, 15'h78), M_ALL);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
